// File: rtl/dp_ram_tx_stream.sv
// Transmit RAM: Avalon-MM CSR loads a simple dual-port RAM, and a playback engine streams a
// programmed window (BASE, LEN) over valid/ready, once or looping.
module dp_ram_tx_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 11,
   parameter int ID         = 1
) (
   input  logic                  avalon_clock,
   input  logic                  resetn,
   input  logic                  read,
   input  logic                  write,
   input  logic [2:0]            address,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  tx_last,
   output logic                  busy
);
   localparam int LW = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM} state_t;
   state_t r_state, w_state_nxt;

   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] r_wptr, r_base, r_base_w;
   logic [LW-1:0]         r_len, r_len_w, r_idx, r_count;
   logic                  r_we, r_loop, r_issue_stop;
   logic [31:0]           r_readdata, w_csr_rd;
   logic                  r_rd_vld, r_rd_last, r_sk_vld, r_sk_last;
   logic [DATA_WIDTH-1:0] r_rd_data, r_sk_data;
   logic                  w_start, w_stop, w_start_ok, w_pop, w_pop_last, w_head_last;
   logic                  w_issue, w_idx_last, w_end_pass, w_flush;
   logic [ADDR_WIDTH-1:0] w_rd_addr;

   assign w_stop     = write && (address == 3'd6) && writedata[1];
   assign w_start    = write && (address == 3'd6) && writedata[0] && !writedata[1];
   assign w_start_ok = (r_state == S_IDLE) && w_start && (r_len != '0);

   // Output buffer: the RAM output register plus a skid entry holding the older word.
   assign tx_valid    = r_sk_vld || r_rd_vld;
   assign tx_data     = r_sk_vld ? r_sk_data : r_rd_data;
   assign w_head_last = r_sk_vld ? r_sk_last : r_rd_last;
   assign tx_last     = tx_valid && w_head_last;
   assign w_pop       = tx_valid && tx_ready;
   assign w_pop_last  = w_pop && w_head_last;
   assign w_end_pass  = (r_state == S_STREAM) && w_pop_last && !r_loop;
   assign w_flush     = w_stop || w_end_pass;
   assign w_idx_last  = (r_idx == r_len_w - LW'(1));
   assign w_rd_addr   = r_base_w + r_idx[ADDR_WIDTH-1:0];
   assign w_issue     = !w_flush && (!r_sk_vld || w_pop) &&
                        ((r_state == S_PRIME) || ((r_state == S_STREAM) && !r_issue_stop));
   assign busy        = (r_state != S_IDLE);
   assign readdata    = r_readdata;

   always_ff @(posedge avalon_clock) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_start_ok) w_state_nxt = S_PRIME;
         S_PRIME:  w_state_nxt = S_STREAM;
         S_STREAM: if (w_end_pass) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
      if (w_stop) w_state_nxt = S_IDLE;
   end

   always_comb begin
      w_csr_rd = '0;
      case (address)
         3'd1: w_csr_rd[ADDR_WIDTH-1:0] = r_wptr;
         3'd2: w_csr_rd[1:0] = {r_loop, r_we};
         3'd3: w_csr_rd = 32'(ID);
         3'd4: w_csr_rd[ADDR_WIDTH-1:0] = r_base;
         3'd5: w_csr_rd[LW-1:0] = r_len;
         3'd7: begin
            w_csr_rd[0]                 = busy;
            w_csr_rd[ADDR_WIDTH+16:16] = r_count;
         end
         default: ;
      endcase
   end

   always_ff @(posedge avalon_clock) begin
      if (!resetn) begin
         r_wptr       <= '0;
         r_we         <= 1'b0;
         r_loop       <= 1'b0;
         r_base       <= '0;
         r_len        <= '0;
         r_readdata   <= '0;
         r_rd_vld     <= 1'b0;
         r_sk_vld     <= 1'b0;
         r_idx        <= '0;
         r_issue_stop <= 1'b0;
         r_count      <= '0;
      end else begin
         if (write) begin
            case (address)
               3'd0: r_wptr <= r_wptr + ADDR_WIDTH'(1);
               3'd1: r_wptr <= writedata[ADDR_WIDTH-1:0];
               3'd2: begin
                  r_we   <= writedata[0];
                  r_loop <= writedata[1];
               end
               3'd4: r_base <= writedata[ADDR_WIDTH-1:0];
               3'd5: r_len  <= writedata[LW-1:0];
               default: ;
            endcase
         end
         if (read) r_readdata <= w_csr_rd;
         if (w_flush) begin
            r_rd_vld <= 1'b0;
            r_sk_vld <= 1'b0;
         end else begin
            r_rd_vld <= w_issue || (r_rd_vld && r_sk_vld && !w_pop);
            if (!r_sk_vld)  r_sk_vld <= r_rd_vld && !w_pop;
            else if (w_pop) r_sk_vld <= r_rd_vld;
         end
         // The LOOP bit seen when the last word of a pass is fetched decides whether to prefetch on.
         if (w_issue) begin
            if (w_idx_last) begin
               r_idx        <= '0;
               r_issue_stop <= !r_loop;
            end else begin
               r_idx <= r_idx + LW'(1);
            end
         end
         if (w_pop_last && r_loop) r_issue_stop <= 1'b0;
         if (w_pop && (r_count != '1)) r_count <= r_count + LW'(1);
         if (w_start_ok) begin
            r_idx        <= '0;
            r_issue_stop <= 1'b0;
            r_count      <= '0;
         end
      end
   end

   // RAM and data path: no reset; a same-cycle write to the read address yields the old word.
   always_ff @(posedge avalon_clock) begin
      if (write && (address == 3'd0) && r_we) r_mem[r_wptr] <= writedata[DATA_WIDTH-1:0];
      if (w_issue) begin
         r_rd_data <= r_mem[w_rd_addr];
         r_rd_last <= w_idx_last;
      end
      if (!r_sk_vld || w_pop) begin
         r_sk_data <= r_rd_data;
         r_sk_last <= r_rd_last;
      end
      if (w_start_ok) begin
         r_base_w <= r_base;
         r_len_w  <= r_len;
      end
   end
endmodule

// File: tb/tb_dp_ram_tx_stream.sv
// Directed bench for dp_ram_tx_stream: CSR vector table plus hand-written streaming sequences.
module tb_dp_ram_tx_stream;
   logic        avalon_clock = 1'b0;
   logic        resetn = 1'b0, read = 1'b0, write = 1'b0, tx_ready = 1'b0;
   logic [2:0]  address = '0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata, tx_data;
   logic        tx_valid, tx_last, busy;

   always #5 avalon_clock = ~avalon_clock;

   dp_ram_tx_stream #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .ID(1)) dut (
      .avalon_clock(avalon_clock), .resetn(resetn), .read(read), .write(write),
      .address(address), .writedata(writedata), .readdata(readdata),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_last(tx_last), .busy(busy)
   );

   typedef struct {
      bit        wr;
      bit [2:0]  addr;
      bit [31:0] data;
      bit [31:0] exp;
   } vec_t;

   vec_t        tbl[$];
   int          vecs = 0, errs = 0;
   bit [31:0]   mdl_mem [2048];
   int          mdl_wptr = 0;
   bit          mdl_we = 1'b0;
   logic [31:0] rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge avalon_clock);
      #1;
   endtask

   task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
      write = 1'b1; address = a; writedata = d;
      tick();
      write = 1'b0;
      if (a == 3'd0) begin
         if (mdl_we) mdl_mem[mdl_wptr] = d;
         mdl_wptr = (mdl_wptr + 1) % 2048;
      end
      if (a == 3'd1) mdl_wptr = int'(d[10:0]);
      if (a == 3'd2) mdl_we = d[0];
   endtask

   task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
      read = 1'b1; address = a;
      tick();
      read = 1'b0;
      d = readdata;
   endtask

   // Accepts n words starting at pass index k0, checking data, tx_last and stall stability.
   task automatic consume(input int base, input int len, input int k0, input int n,
                          input int pct, input bit tput);
      int          got = 0;
      int          cyc = 0;
      int          k;
      logic [31:0] held = '0;
      bit          stalled = 1'b0;
      while (got < n && cyc < 400) begin
         tx_ready = ($urandom_range(0, 99) < pct);
         if (stalled) begin
            chk("stall_valid", 32'(tx_valid), 32'd1);
            chk("stall_data", tx_data, held);
         end
         if (tx_valid && tx_ready) begin
            k = k0 + got;
            chk($sformatf("word%0d", k), tx_data, mdl_mem[(base + k % len) % 2048]);
            chk($sformatf("last%0d", k), 32'(tx_last), 32'((k % len) == len - 1));
            got++;
            stalled = 1'b0;
         end else begin
            stalled = tx_valid;
            held    = tx_data;
         end
         tick();
         cyc++;
      end
      tx_ready = 1'b0;
      if (got < n) begin
         vecs++; errs++;
         $display("FAIL stream_timeout: got %0d words expected %0d", got, n);
      end
      if (tput) chk("throughput_cycles", 32'(cyc), 32'(n));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl.push_back('{1'b1, 3'd2, 32'h1,        32'h0});
      tbl.push_back('{1'b1, 3'd1, 32'h0,        32'h0});
      tbl.push_back('{1'b1, 3'd0, 32'hA0,       32'h0});
      tbl.push_back('{1'b1, 3'd0, 32'hA1,       32'h0});
      tbl.push_back('{1'b1, 3'd0, 32'hA2,       32'h0});
      tbl.push_back('{1'b1, 3'd0, 32'hA3,       32'h0});
      tbl.push_back('{1'b0, 3'd1, 32'h0,        32'd4});
      tbl.push_back('{1'b0, 3'd2, 32'h0,        32'h1});
      tbl.push_back('{1'b0, 3'd0, 32'h0,        32'h0});
      tbl.push_back('{1'b1, 3'd1, 32'd2046,     32'h0});
      tbl.push_back('{1'b1, 3'd0, 32'hB0,       32'h0});
      tbl.push_back('{1'b1, 3'd0, 32'hB1,       32'h0});
      tbl.push_back('{1'b0, 3'd1, 32'h0,        32'd0});
      tbl.push_back('{1'b1, 3'd1, 32'd10,       32'h0});
      tbl.push_back('{1'b1, 3'd0, 32'hC0,       32'h0});
      tbl.push_back('{1'b1, 3'd2, 32'h0,        32'h0});
      tbl.push_back('{1'b1, 3'd1, 32'd10,       32'h0});
      tbl.push_back('{1'b1, 3'd0, 32'hDEAD,     32'h0});
      tbl.push_back('{1'b0, 3'd1, 32'h0,        32'd11});
      tbl.push_back('{1'b0, 3'd2, 32'h0,        32'h0});
      tbl.push_back('{1'b1, 3'd2, 32'h1,        32'h0});
      tbl.push_back('{1'b1, 3'd4, 32'hFFFFF805, 32'h0});
      tbl.push_back('{1'b0, 3'd4, 32'h0,        32'h005});
      tbl.push_back('{1'b1, 3'd5, 32'hFFFFFFFF, 32'h0});
      tbl.push_back('{1'b0, 3'd5, 32'h0,        32'hFFF});
      tbl.push_back('{1'b0, 3'd6, 32'h0,        32'h0});
      tbl.push_back('{1'b0, 3'd3, 32'h0,        32'h1});
      tbl.push_back('{1'b0, 3'd7, 32'h0,        32'h0});
      tbl.push_back('{1'b1, 3'd5, 32'd4,        32'h0});
      tbl.push_back('{1'b1, 3'd4, 32'd0,        32'h0});

      tick(); tick();
      resetn = 1'b1;

      // Reset clears WPTR and stream outputs
      csr_wr(3'd1, 32'd5);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      mdl_wptr = 0;
      csr_rd(3'd1, rd);
      chk("rst_wptr", rd, 32'd0);
      chk("rst_valid", 32'(tx_valid), 32'd0);
      chk("rst_last", 32'(tx_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      csr_rd(3'd3, rd);
      chk("rst_id", rd, 32'd1);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].wr) begin
            csr_wr(tbl[i].addr, tbl[i].data);
         end else begin
            csr_rd(tbl[i].addr, rd);
            chk($sformatf("vec%0d_addr%0d", i, tbl[i].addr), rd, tbl[i].exp);
         end
      end

      // Single pass, full rate: first word two cycles after START
      csr_wr(3'd6, 32'h1);
      chk("lat_cycle1_valid", 32'(tx_valid), 32'd0);
      chk("start_busy", 32'(busy), 32'd1);
      tick();
      chk("lat_cycle2_valid", 32'(tx_valid), 32'd1);
      chk("first_word", tx_data, 32'hA0);
      consume(0, 4, 0, 4, 100, 1'b1);
      chk("pass_done_busy", 32'(busy), 32'd0);
      chk("pass_done_valid", 32'(tx_valid), 32'd0);
      csr_rd(3'd7, rd);
      chk("stat_after_pass", rd, 32'h0004_0000);

      // Random backpressure
      csr_wr(3'd6, 32'h1);
      tick();
      consume(0, 4, 0, 4, 50, 1'b0);
      chk("bp_done_busy", 32'(busy), 32'd0);

      // Window wrapping past the top of the RAM: B0, B1, A0, A1
      csr_wr(3'd4, 32'd2046);
      csr_wr(3'd6, 32'h1);
      tick();
      chk("wrap_first", tx_data, 32'hB0);
      consume(2046, 4, 0, 4, 100, 1'b1);

      // DATA write with WE=0 left address 10 holding C0
      csr_wr(3'd4, 32'd10);
      csr_wr(3'd5, 32'd1);
      csr_wr(3'd6, 32'h1);
      tick();
      chk("we0_keep", tx_data, 32'hC0);
      consume(10, 1, 0, 1, 100, 1'b1);

      // START with LEN=0 is a no-op
      csr_wr(3'd5, 32'd0);
      csr_wr(3'd6, 32'h1);
      chk("len0_busy", 32'(busy), 32'd0);
      tick();
      chk("len0_busy_later", 32'(busy), 32'd0);
      chk("len0_valid", 32'(tx_valid), 32'd0);

      // Looping LEN=3, START while busy ignored, then STOP
      csr_wr(3'd2, 32'h3);
      csr_wr(3'd4, 32'd0);
      csr_wr(3'd5, 32'd3);
      csr_wr(3'd6, 32'h1);
      tick();
      consume(0, 3, 0, 7, 100, 1'b1);
      chk("loop_busy", 32'(busy), 32'd1);
      chk("loop_held_valid", 32'(tx_valid), 32'd1);
      csr_wr(3'd4, 32'd2046);
      csr_wr(3'd6, 32'h1);
      consume(0, 3, 7, 3, 100, 1'b0);
      csr_rd(3'd4, rd);
      chk("base_csr_updated", rd, 32'd2046);
      csr_wr(3'd6, 32'h2);
      chk("stop_valid", 32'(tx_valid), 32'd0);
      chk("stop_busy", 32'(busy), 32'd0);
      tick();
      chk("stop_valid_later", 32'(tx_valid), 32'd0);

      // Accepted-word counter saturates in loop mode
      csr_wr(3'd4, 32'd0);
      csr_wr(3'd5, 32'd1);
      csr_wr(3'd6, 32'h1);
      tx_ready = 1'b1;
      repeat (4200) tick();
      tx_ready = 1'b0;
      csr_rd(3'd7, rd);
      chk("count_saturate", rd, 32'h0FFF_0001);
      csr_wr(3'd6, 32'h2);
      chk("sat_stop_busy", 32'(busy), 32'd0);

      // START and STOP together: STOP wins
      csr_wr(3'd6, 32'h3);
      chk("start_stop_busy", 32'(busy), 32'd0);
      tick();
      chk("start_stop_valid", 32'(tx_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
